// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, state encodings and helpers for the
// byte-serial memory controller (mem_ctrl and its pending-request slots).
package mem_ctrl_pkg;

    localparam int          ADDR_W_DEF       = 32;
    localparam int          DATA_W_DEF       = 32;
    localparam logic [31:0] IO_ADDR_BASE_DEF = 32'h30000;

    // Request direction encoding used by both requesters
    localparam logic READ_FLAG  = 1'b0;
    localparam logic WRITE_FLAG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic {
        SRC_LSU   = 1'b0,
        SRC_FETCH = 1'b1
    } src_t;

    // Byte count of a request; any size other than 1 or 2 is a word access
    function automatic logic [2:0] byte_count(input logic [2:0] size);
        case (size)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_pending_slot.sv
// mem_ctrl_pending_slot: one-entry holding register for a requester.
// Captures a one-cycle request pulse and keeps it until the controller
// accepts it. A same-cycle pulse is presented straight through so it can be
// accepted on the very edge it arrives. The flush input drops read requests
// only; a pending write always survives.
module mem_ctrl_pending_slot
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_pulse,
    input  logic              req_rw,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              accept,
    input  logic              flush,
    output logic              out_vld,
    output logic              out_rw,
    output logic [2:0]        out_size,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    logic              held;
    logic              held_rw;
    logic [2:0]        held_size;
    logic [ADDR_W-1:0] held_addr;
    logic [DATA_W-1:0] held_data;
    logic              flushed;

    assign out_rw   = held ? held_rw   : req_rw;
    assign out_size = held ? held_size : req_size;
    assign out_addr = held ? held_addr : req_addr;
    assign out_data = held ? held_data : req_data;
    assign flushed  = flush && (out_rw == READ_FLAG);
    assign out_vld  = (held || req_pulse) && !flushed;

    // Occupancy: set by a pulse, cleared when accepted or flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            held <= 1'b0;
        end else if (rdy) begin
            if (accept || flushed) begin
                held <= 1'b0;
            end else if (req_pulse) begin
                held <= 1'b1;
            end
        end
    end

    // Request fields: captured only into an empty slot so a held request is not overwritten
    always_ff @(posedge clk) begin
        if (rdy && req_pulse && !held) begin
            held_rw   <= req_rw;
            held_size <= req_size;
            held_addr <= req_addr;
            held_data <= req_data;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO controller serving the LSU and the
// instruction fetcher. Requests are serialised into little-endian byte
// accesses; LSU wins ties. Reads are abandoned on misbranch, writes never.
// Optional build macro IO_BUFFER_STALL_EN: hold IO-space write bytes while
// the UART buffer reports full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                DATA_W       = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] IO_ADDR_BASE = IO_ADDR_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              enable_signal_from_lsu,
    input  logic              read_or_write_flag_from_lsu,
    input  logic [2:0]        size_from_lsu,
    input  logic [ADDR_W-1:0] address_from_lsu,
    input  logic [DATA_W-1:0] data_from_lsu,
    output logic              finish_flag_to_lsu,
    output logic [DATA_W-1:0] data_to_lsu,
    input  logic              enable_signal_from_fetcher,
    input  logic [ADDR_W-1:0] address_from_fetcher,
    output logic              finish_flag_to_fetcher,
    output logic [DATA_W-1:0] inst_to_fetcher,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              misbranch_flag
);

    state_t            state;
    src_t              cur_src;
    logic [2:0]        step;
    logic [2:0]        cur_n;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [DATA_W-1:0] rd_buf;
    logic [DATA_W-1:0] rd_buf_nxt;

    logic              lsu_vld;
    logic              lsu_rw;
    logic [2:0]        lsu_size;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_data;
    logic              fet_vld;
    logic              fet_rw_unused;
    logic [2:0]        fet_size;
    logic [ADDR_W-1:0] fet_addr;
    logic [DATA_W-1:0] fet_data_unused;

    logic              is_idle;
    logic              accept_lsu;
    logic              accept_fet;
    logic              sel_rw;
    logic [2:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] byte_addr;
    logic [DATA_W-1:0] wr_shift;
    logic [1:0]        rd_sel;
    logic              stall_first;
    logic              stall_cur;

    assign is_idle    = (state == ST_IDLE);
    assign accept_lsu = rdy && is_idle && lsu_vld;
    assign accept_fet = rdy && is_idle && !lsu_vld && fet_vld;

    mem_ctrl_pending_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lsu_slot (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .req_pulse (enable_signal_from_lsu),
        .req_rw    (read_or_write_flag_from_lsu),
        .req_size  (size_from_lsu),
        .req_addr  (address_from_lsu),
        .req_data  (data_from_lsu),
        .accept    (accept_lsu),
        .flush     (misbranch_flag),
        .out_vld   (lsu_vld),
        .out_rw    (lsu_rw),
        .out_size  (lsu_size),
        .out_addr  (lsu_addr),
        .out_data  (lsu_data)
    );

    mem_ctrl_pending_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fet_slot (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .req_pulse (enable_signal_from_fetcher),
        .req_rw    (READ_FLAG),
        .req_size  (3'd4),
        .req_addr  (address_from_fetcher),
        .req_data  ('0),
        .accept    (accept_fet),
        .flush     (misbranch_flag),
        .out_vld   (fet_vld),
        .out_rw    (fet_rw_unused),
        .out_size  (fet_size),
        .out_addr  (fet_addr),
        .out_data  (fet_data_unused)
    );

    // The fetcher never writes, so only the LSU supplies write data
    assign sel_rw   = lsu_vld ? lsu_rw   : READ_FLAG;
    assign sel_size = lsu_vld ? lsu_size : fet_size;
    assign sel_addr = lsu_vld ? lsu_addr : fet_addr;

    assign byte_addr = cur_addr + ADDR_W'(step);
    assign wr_shift  = cur_data >> {step[1:0], 3'b000};
    // Read byte i is sampled when step == i + 2
    assign rd_sel    = step[1:0] - 2'd2;

`ifdef IO_BUFFER_STALL_EN
    assign stall_first = io_buffer_full && (sel_addr >= IO_ADDR_BASE);
    assign stall_cur   = io_buffer_full && (byte_addr >= IO_ADDR_BASE);
`else
    logic io_full_unused;
    assign io_full_unused = io_buffer_full;
    assign stall_first    = 1'b0;
    assign stall_cur      = 1'b0;
`endif

    // Read assembly: drop the incoming byte into its little-endian lane
    always_comb begin
        rd_buf_nxt = rd_buf;
        rd_buf_nxt[{rd_sel, 3'b000} +: 8] = mem_din;
    end

    // Main FSM: accept, serialise byte accesses and pulse finish to the owner
    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= ST_IDLE;
            cur_src                <= SRC_LSU;
            step                   <= 3'd0;
            finish_flag_to_lsu     <= 1'b0;
            finish_flag_to_fetcher <= 1'b0;
            mem_wr                 <= 1'b0;
            mem_a                  <= '0;
            mem_dout               <= 8'h00;
            data_to_lsu            <= '0;
            inst_to_fetcher        <= '0;
            rd_buf                 <= '0;
        end else if (rdy) begin
            finish_flag_to_lsu     <= 1'b0;
            finish_flag_to_fetcher <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_wr <= 1'b0;
                    if (lsu_vld || fet_vld) begin
                        cur_src  <= lsu_vld ? SRC_LSU : SRC_FETCH;
                        cur_addr <= sel_addr;
                        cur_data <= lsu_data;
                        cur_n    <= byte_count(sel_size);
                        rd_buf   <= '0;
                        mem_a    <= sel_addr;
                        if (sel_rw == WRITE_FLAG) begin
                            state    <= ST_WRITE;
                            mem_dout <= lsu_data[7:0];
                            if (stall_first) begin
                                mem_wr <= 1'b0;
                                step   <= 3'd0;
                            end else begin
                                mem_wr <= 1'b1;
                                step   <= 3'd1;
                            end
                        end else begin
                            state <= ST_READ;
                            step  <= 3'd1;
                        end
                    end
                end
                ST_READ: begin
                    mem_wr <= 1'b0;
                    if (misbranch_flag) begin
                        state <= ST_IDLE;
                    end else begin
                        if (step < cur_n) begin
                            mem_a <= byte_addr;
                        end
                        if (step >= 3'd2) begin
                            rd_buf <= rd_buf_nxt;
                        end
                        if (step == cur_n + 3'd1) begin
                            state <= ST_IDLE;
                            if (cur_src == SRC_LSU) begin
                                finish_flag_to_lsu <= 1'b1;
                                data_to_lsu        <= rd_buf_nxt;
                            end else begin
                                finish_flag_to_fetcher <= 1'b1;
                                inst_to_fetcher        <= rd_buf_nxt;
                            end
                        end
                        step <= step + 3'd1;
                    end
                end
                ST_WRITE: begin
                    if (step < cur_n) begin
                        mem_a    <= byte_addr;
                        mem_dout <= wr_shift[7:0];
                        if (stall_cur) begin
                            mem_wr <= 1'b0;
                        end else begin
                            mem_wr <= 1'b1;
                            step   <= step + 3'd1;
                        end
                    end else begin
                        mem_wr             <= 1'b0;
                        finish_flag_to_lsu <= 1'b1;
                        state              <= ST_IDLE;
                    end
                end
                default: begin
                    mem_wr <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a one-cycle-latency RAM model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        enable_signal_from_lsu;
    logic        read_or_write_flag_from_lsu;
    logic [2:0]  size_from_lsu;
    logic [31:0] address_from_lsu;
    logic [31:0] data_from_lsu;
    logic        finish_flag_to_lsu;
    logic [31:0] data_to_lsu;
    logic        enable_signal_from_fetcher;
    logic [31:0] address_from_fetcher;
    logic        finish_flag_to_fetcher;
    logic [31:0] inst_to_fetcher;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        misbranch_flag;

    int n_cmp = 0;
    int n_bad = 0;
    int kk;

    logic [7:0]  ram [int];
    logic [47:0] obs_wr [$];
    logic [47:0] exp_wr [$];
    logic [39:0] obs_lsu [$];
    logic [39:0] exp_lsu [$];
    logic [39:0] obs_fet [$];
    logic [39:0] exp_fet [$];

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk                         (clk),
        .rst                         (rst),
        .rdy                         (rdy),
        .enable_signal_from_lsu      (enable_signal_from_lsu),
        .read_or_write_flag_from_lsu (read_or_write_flag_from_lsu),
        .size_from_lsu               (size_from_lsu),
        .address_from_lsu            (address_from_lsu),
        .data_from_lsu               (data_from_lsu),
        .finish_flag_to_lsu          (finish_flag_to_lsu),
        .data_to_lsu                 (data_to_lsu),
        .enable_signal_from_fetcher  (enable_signal_from_fetcher),
        .address_from_fetcher        (address_from_fetcher),
        .finish_flag_to_fetcher      (finish_flag_to_fetcher),
        .inst_to_fetcher             (inst_to_fetcher),
        .mem_din                     (mem_din),
        .mem_dout                    (mem_dout),
        .mem_a                       (mem_a),
        .mem_wr                      (mem_wr),
        .io_buffer_full              (io_buffer_full),
        .misbranch_flag              (misbranch_flag)
    );

    // RAM model: read data appears one cycle after the address; halts with rdy
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= ram.exists(int'(mem_a)) ? ram[int'(mem_a)] : 8'h00;
            if (mem_wr) ram[int'(mem_a)] = mem_dout;
        end
    end

    task automatic clear_obs();
        kk = -1;
        obs_wr.delete();
        obs_lsu.delete();
        obs_fet.delete();
    endtask

    // Advance n edges; kk == 0 is the edge on which the request is accepted
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            enable_signal_from_lsu     = 1'b0;
            enable_signal_from_fetcher = 1'b0;
            kk++;
            if (mem_wr) obs_wr.push_back({kk[7:0], mem_a, mem_dout});
            if (finish_flag_to_lsu) obs_lsu.push_back({kk[7:0], data_to_lsu});
            if (finish_flag_to_fetcher) obs_fet.push_back({kk[7:0], inst_to_fetcher});
        end
    endtask

    task automatic issue(input logic l_en, input logic rw, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic f_en, input logic [31:0] faddr);
        enable_signal_from_lsu      = l_en;
        read_or_write_flag_from_lsu = rw;
        size_from_lsu               = size;
        address_from_lsu            = addr;
        data_from_lsu               = data;
        enable_signal_from_fetcher  = f_en;
        address_from_fetcher        = faddr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (finish_flag_to_lsu !== 1'b0) begin n_bad++; $display("FAIL reset_fin_lsu got %b want 0", finish_flag_to_lsu); end
        n_cmp++; if (finish_flag_to_fetcher !== 1'b0) begin n_bad++; $display("FAIL reset_fin_fet got %b want 0", finish_flag_to_fetcher); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        n_cmp++; if (mem_a !== 32'h0) begin n_bad++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
        n_cmp++; if (mem_dout !== 8'h0) begin n_bad++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
        n_cmp++; if (data_to_lsu !== 32'h0) begin n_bad++; $display("FAIL reset_data_to_lsu got %h want 0", data_to_lsu); end
        n_cmp++; if (inst_to_fetcher !== 32'h0) begin n_bad++; $display("FAIL reset_inst got %h want 0", inst_to_fetcher); end
        rst = 1'b0;
    endtask

    task automatic test_lw();
        logic [39:0] o, e;
        clear_obs();
        exp_lsu.push_back({8'd5, 32'h44332211});
        issue(1'b1, READ_FLAG, 3'd4, 32'h100, 32'h0, 1'b0, 32'h0);
        run_cycles(9);
        n_cmp++; if (obs_lsu.size() != exp_lsu.size()) begin n_bad++; $display("FAIL lw_count got %0d want %0d", obs_lsu.size(), exp_lsu.size()); end
        while (obs_lsu.size() > 0 && exp_lsu.size() > 0) begin
            o = obs_lsu.pop_front(); e = exp_lsu.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL lw_result got k=%0d data=%h want k=%0d data=%h", o[39:32], o[31:0], e[39:32], e[31:0]); end
        end
        n_cmp++; if (obs_wr.size() != 0 || obs_fet.size() != 0) begin n_bad++; $display("FAIL lw_side_effects got wr=%0d fet=%0d want 0 0", obs_wr.size(), obs_fet.size()); end
        exp_lsu.delete();
    endtask

    task automatic test_sh();
        logic [47:0] ow, ew;
        logic [39:0] o;
        clear_obs();
        exp_wr.push_back({8'd0, 32'h200, 8'h34});
        exp_wr.push_back({8'd1, 32'h201, 8'h12});
        issue(1'b1, WRITE_FLAG, 3'd2, 32'h200, 32'hABCD1234, 1'b0, 32'h0);
        run_cycles(6);
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL sh_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            ow = obs_wr.pop_front(); ew = exp_wr.pop_front();
            n_cmp++; if (ow !== ew) begin n_bad++; $display("FAIL sh_write got k=%0d a=%h d=%h want k=%0d a=%h d=%h", ow[47:40], ow[39:8], ow[7:0], ew[47:40], ew[39:8], ew[7:0]); end
        end
        n_cmp++; if (obs_lsu.size() != 1) begin n_bad++; $display("FAIL sh_fin_count got %0d want 1", obs_lsu.size()); end
        if (obs_lsu.size() > 0) begin
            o = obs_lsu.pop_front();
            n_cmp++; if (o[39:32] !== 8'd2) begin n_bad++; $display("FAIL sh_fin_time got k=%0d want k=2", o[39:32]); end
        end
        exp_wr.delete();
    endtask

    task automatic test_tie();
        logic [39:0] o, e;
        clear_obs();
        exp_lsu.push_back({8'd2, 32'h000000A5});
        exp_fet.push_back({8'd8, 32'h00000513});
        issue(1'b1, READ_FLAG, 3'd1, 32'h10, 32'h0, 1'b1, 32'h0);
        run_cycles(12);
        n_cmp++; if (obs_lsu.size() != exp_lsu.size()) begin n_bad++; $display("FAIL tie_lsu_count got %0d want %0d", obs_lsu.size(), exp_lsu.size()); end
        while (obs_lsu.size() > 0 && exp_lsu.size() > 0) begin
            o = obs_lsu.pop_front(); e = exp_lsu.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL tie_lb got k=%0d data=%h want k=%0d data=%h", o[39:32], o[31:0], e[39:32], e[31:0]); end
        end
        n_cmp++; if (obs_fet.size() != exp_fet.size()) begin n_bad++; $display("FAIL tie_fet_count got %0d want %0d", obs_fet.size(), exp_fet.size()); end
        while (obs_fet.size() > 0 && exp_fet.size() > 0) begin
            o = obs_fet.pop_front(); e = exp_fet.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL tie_fetch got k=%0d inst=%h want k=%0d inst=%h", o[39:32], o[31:0], e[39:32], e[31:0]); end
        end
        exp_lsu.delete(); exp_fet.delete();
    endtask

    task automatic test_misbranch_read();
        logic [39:0] o, e;
        // Word load aborted mid-flight
        clear_obs();
        issue(1'b1, READ_FLAG, 3'd4, 32'h100, 32'h0, 1'b0, 32'h0);
        run_cycles(3);
        misbranch_flag = 1'b1;
        run_cycles(1);
        misbranch_flag = 1'b0;
        run_cycles(6);
        n_cmp++; if (obs_lsu.size() != 0) begin n_bad++; $display("FAIL mb_lw_finish got %0d pulses want 0", obs_lsu.size()); end
        // Byte load aborted on the edge its finish was due
        clear_obs();
        issue(1'b1, READ_FLAG, 3'd1, 32'h10, 32'h0, 1'b0, 32'h0);
        run_cycles(2);
        misbranch_flag = 1'b1;
        run_cycles(1);
        misbranch_flag = 1'b0;
        run_cycles(4);
        n_cmp++; if (obs_lsu.size() != 0) begin n_bad++; $display("FAIL mb_lb_finish got %0d pulses want 0", obs_lsu.size()); end
        // The controller must be free for the redirected fetch
        clear_obs();
        exp_fet.push_back({8'd5, 32'h00000513});
        issue(1'b0, READ_FLAG, 3'd1, 32'h0, 32'h0, 1'b1, 32'h0);
        run_cycles(8);
        n_cmp++; if (obs_fet.size() != exp_fet.size()) begin n_bad++; $display("FAIL mb_fet_count got %0d want %0d", obs_fet.size(), exp_fet.size()); end
        while (obs_fet.size() > 0 && exp_fet.size() > 0) begin
            o = obs_fet.pop_front(); e = exp_fet.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL mb_fetch got k=%0d inst=%h want k=%0d inst=%h", o[39:32], o[31:0], e[39:32], e[31:0]); end
        end
        exp_fet.delete();
    endtask

    task automatic test_sw_misbranch();
        logic [47:0] ow, ew;
        logic [39:0] o;
        clear_obs();
        exp_wr.push_back({8'd0, 32'h300, 8'hEF});
        exp_wr.push_back({8'd1, 32'h301, 8'hBE});
        exp_wr.push_back({8'd2, 32'h302, 8'hAD});
        exp_wr.push_back({8'd3, 32'h303, 8'hDE});
        issue(1'b1, WRITE_FLAG, 3'd4, 32'h300, 32'hDEADBEEF, 1'b0, 32'h0);
        run_cycles(2);
        misbranch_flag = 1'b1;
        run_cycles(1);
        misbranch_flag = 1'b0;
        run_cycles(5);
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL sw_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            ow = obs_wr.pop_front(); ew = exp_wr.pop_front();
            n_cmp++; if (ow !== ew) begin n_bad++; $display("FAIL sw_write got k=%0d a=%h d=%h want k=%0d a=%h d=%h", ow[47:40], ow[39:8], ow[7:0], ew[47:40], ew[39:8], ew[7:0]); end
        end
        n_cmp++; if (obs_lsu.size() != 1) begin n_bad++; $display("FAIL sw_fin_count got %0d want 1", obs_lsu.size()); end
        if (obs_lsu.size() > 0) begin
            o = obs_lsu.pop_front();
            n_cmp++; if (o[39:32] !== 8'd4) begin n_bad++; $display("FAIL sw_fin_time got k=%0d want k=4", o[39:32]); end
        end
        exp_wr.delete();
    endtask

    task automatic test_back_to_back();
        logic [39:0] o, e;
        clear_obs();
        exp_lsu.push_back({8'd2, 32'h00000011});
        exp_lsu.push_back({8'd8, 32'h44332211});
        issue(1'b1, READ_FLAG, 3'd1, 32'h100, 32'h0, 1'b0, 32'h0);
        run_cycles(3);
        // Size 7 behaves as a word access
        issue(1'b1, READ_FLAG, 3'd7, 32'h100, 32'h0, 1'b0, 32'h0);
        run_cycles(9);
        n_cmp++; if (obs_lsu.size() != exp_lsu.size()) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", obs_lsu.size(), exp_lsu.size()); end
        while (obs_lsu.size() > 0 && exp_lsu.size() > 0) begin
            o = obs_lsu.pop_front(); e = exp_lsu.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL b2b_result got k=%0d data=%h want k=%0d data=%h", o[39:32], o[31:0], e[39:32], e[31:0]); end
        end
        exp_lsu.delete();
    endtask

    task automatic test_rdy_freeze();
        logic [39:0] o, e;
        clear_obs();
        exp_lsu.push_back({8'd8, 32'h44332211});
        issue(1'b1, READ_FLAG, 3'd4, 32'h100, 32'h0, 1'b0, 32'h0);
        run_cycles(2);
        rdy = 1'b0;
        run_cycles(3);
        rdy = 1'b1;
        run_cycles(7);
        n_cmp++; if (obs_lsu.size() != exp_lsu.size()) begin n_bad++; $display("FAIL frz_count got %0d want %0d", obs_lsu.size(), exp_lsu.size()); end
        while (obs_lsu.size() > 0 && exp_lsu.size() > 0) begin
            o = obs_lsu.pop_front(); e = exp_lsu.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL frz_result got k=%0d data=%h want k=%0d data=%h", o[39:32], o[31:0], e[39:32], e[31:0]); end
        end
        exp_lsu.delete();
    endtask

    task automatic test_io_write();
        logic [47:0] ow, ew;
        logic [39:0] o;
        int fin_k;
        clear_obs();
        io_buffer_full = 1'b1;
        issue(1'b1, WRITE_FLAG, 3'd1, 32'h30000, 32'h0000005A, 1'b0, 32'h0);
`ifdef IO_BUFFER_STALL_EN
        exp_wr.push_back({8'd3, 32'h30000, 8'h5A});
        fin_k = 4;
        run_cycles(3);
        io_buffer_full = 1'b0;
        run_cycles(4);
`else
        exp_wr.push_back({8'd0, 32'h30000, 8'h5A});
        fin_k = 1;
        run_cycles(6);
        io_buffer_full = 1'b0;
`endif
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL io_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            ow = obs_wr.pop_front(); ew = exp_wr.pop_front();
            n_cmp++; if (ow !== ew) begin n_bad++; $display("FAIL io_write got k=%0d a=%h d=%h want k=%0d a=%h d=%h", ow[47:40], ow[39:8], ow[7:0], ew[47:40], ew[39:8], ew[7:0]); end
        end
        n_cmp++; if (obs_lsu.size() != 1) begin n_bad++; $display("FAIL io_fin_count got %0d want 1", obs_lsu.size()); end
        if (obs_lsu.size() > 0) begin
            o = obs_lsu.pop_front();
            n_cmp++; if (int'(o[39:32]) != fin_k) begin n_bad++; $display("FAIL io_fin_time got k=%0d want k=%0d", o[39:32], fin_k); end
        end
        exp_wr.delete();
    endtask

    task automatic test_reset_mid_op();
        logic [47:0] ow, ew;
        clear_obs();
        exp_wr.push_back({8'd0, 32'h400, 8'h04});
        exp_wr.push_back({8'd1, 32'h401, 8'h03});
        issue(1'b1, WRITE_FLAG, 3'd4, 32'h400, 32'h01020304, 1'b0, 32'h0);
        run_cycles(2);
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL rmid_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            ow = obs_wr.pop_front(); ew = exp_wr.pop_front();
            n_cmp++; if (ow !== ew) begin n_bad++; $display("FAIL rmid_write got k=%0d a=%h d=%h want k=%0d a=%h d=%h", ow[47:40], ow[39:8], ow[7:0], ew[47:40], ew[39:8], ew[7:0]); end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rmid_mem_wr got %b want 0", mem_wr); end
        n_cmp++; if (mem_a !== 32'h0) begin n_bad++; $display("FAIL rmid_mem_a got %h want 0", mem_a); end
        rst = 1'b0;
        clear_obs();
        run_cycles(6);
        n_cmp++; if (obs_wr.size() != 0 || obs_lsu.size() != 0) begin n_bad++; $display("FAIL rmid_after got wr=%0d fin=%0d want 0 0", obs_wr.size(), obs_lsu.size()); end
        exp_wr.delete();
    endtask

    initial begin
        rdy = 1'b1;
        misbranch_flag = 1'b0;
        io_buffer_full = 1'b0;
        issue(1'b0, READ_FLAG, 3'd1, 32'h0, 32'h0, 1'b0, 32'h0);
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h10]  = 8'hA5;
        ram[32'h0] = 8'h13; ram[32'h1] = 8'h05; ram[32'h2] = 8'h00; ram[32'h3] = 8'h00;

        test_reset();
        test_lw();
        test_sh();
        test_tie();
        test_misbranch_read();
        test_sw_misbranch();
        test_back_to_back();
        test_rdy_freeze();
        test_io_write();
        test_reset_mid_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
